// File: rtl/seq_decoder_3to8.sv
// rtl/seq_decoder_3to8.sv - registered 3-to-8 one-hot decoder with handshake and hold time; optional DECODER_PARITY_EN
module seq_decoder_3to8 #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] code,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       y_valid,
  output logic       busy
`ifdef DECODER_PARITY_EN
  ,
  input  logic       par,
  output logic       err
`endif
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("seq_decoder_3to8: HOLD_CYCLES must be in 1..255");
  end

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] y_next;
  logic       accept;
  logic       load;

  // A new code may enter when idle or on the last cycle of a hold; reset blocks it.
  assign in_ready = !rst && (state == IDLE || cnt == 8'd0);
  assign accept   = in_valid && in_ready;

`ifdef DECODER_PARITY_EN
  logic par_ok;
  logic err_next;
  // {par,code} must carry odd parity for the code to be decoded.
  assign par_ok = ^{par, code};
  assign load   = accept && par_ok;
`else
  assign load   = accept;
`endif

  assign y_valid = |y;
  assign busy    = (state == HOLD);

  // Next-state, counter and output selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    y_next     = y;
`ifdef DECODER_PARITY_EN
    err_next   = accept && !par_ok;
`endif
    case (state)
      IDLE: begin
        if (load) begin
          y_next     = 8'b1 << code;
          cnt_next   = RELOAD;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else if (load) begin
          y_next   = 8'b1 << code;
          cnt_next = RELOAD;
        end else begin
          y_next     = 8'h00;
          state_next = IDLE;
        end
      end
      default: begin
        y_next     = 8'h00;
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      y     <= 8'h00;
`ifdef DECODER_PARITY_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      y     <= y_next;
`ifdef DECODER_PARITY_EN
      err   <= err_next;
`endif
    end
  end

endmodule

// File: tb/tb_seq_decoder_3to8.sv
// tb/tb_seq_decoder_3to8.sv - scoreboard bench for seq_decoder_3to8 (HOLD_CYCLES 4 and 1)
module tb_seq_decoder_3to8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv4, rdy4, yv4, busy4;
  logic [2:0] c4;
  logic [7:0] y4;
  logic       iv1, rdy1, yv1, busy1;
  logic [2:0] c1;
  logic [7:0] y1;
`ifdef DECODER_PARITY_EN
  logic par4, err4, par1, err1;
`endif

  int checks = 0;
  int fails  = 0;
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  seq_decoder_3to8 #(.HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .code(c4), .in_ready(rdy4),
    .y(y4), .y_valid(yv4), .busy(busy4)
`ifdef DECODER_PARITY_EN
    , .par(par4), .err(err4)
`endif
  );

  seq_decoder_3to8 #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .code(c1), .in_ready(rdy1),
    .y(y1), .y_valid(yv1), .busy(busy1)
`ifdef DECODER_PARITY_EN
    , .par(par1), .err(err1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a code to the HOLD_CYCLES=4 instance, wait for in_ready, and queue its expected hold.
  task automatic send4(input logic [2:0] c);
    int n;
    iv4 = 1'b1;
    c4  = c;
`ifdef DECODER_PARITY_EN
    par4 = ~(^c);
`endif
    n = 0;
    while (!rdy4 && n < 20) begin
      step();
      n++;
    end
    chk("send4_ready_timeout", n < 20, 1);
    for (int i = 0; i < 4; i++) q4.push_back(8'b1 << c);
    step();
  endtask

  // Monitor for HOLD_CYCLES=4 instance.
  always @(negedge clk) begin
    if (!rst) chk("yv4_vs_y", yv4, |y4);
    if (y4 != 8'h00) begin
      chk("y4_onehot", $countones(y4), 1);
      chk("busy4_when_y", busy4, 1);
      if (q4.size() == 0) chk("y4_unexpected", y4, 8'h00);
      else chk("y4_value", y4, q4.pop_front());
    end
  end

  // Monitor for HOLD_CYCLES=1 instance.
  always @(negedge clk) begin
    if (!rst) chk("yv1_vs_y", yv1, |y1);
    if (y1 != 8'h00) begin
      chk("y1_onehot", $countones(y1), 1);
      if (q1.size() == 0) chk("y1_unexpected", y1, 8'h00);
      else chk("y1_value", y1, q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    iv4 = 1'b1; c4 = 3'd5;
    iv1 = 1'b1; c1 = 3'd5;
`ifdef DECODER_PARITY_EN
    par4 = 1'b0; par1 = 1'b0;
`endif
    // Reset with a valid code presented: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_y4", y4, 8'h00);
      chk("rst_yv4", yv4, 0);
      chk("rst_busy4", busy4, 0);
      chk("rst_rdy4", rdy4, 0);
      chk("rst_rdy1", rdy1, 0);
`ifdef DECODER_PARITY_EN
      chk("rst_err4", err4, 0);
`endif
    end
    iv4 = 1'b0; iv1 = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy4", rdy4, 1);
    step();
    chk("idle_y4", y4, 8'h00);
    chk("idle_rdy4", rdy4, 1);

    // Single decode, code 3.
    send4(3'd3);
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("single_busy", busy4, 1);
      chk("single_rdy", rdy4, (i == 3) ? 1 : 0);
      chk("single_y", y4, 8'h08);
      step();
    end
    chk("single_end_y", y4, 8'h00);
    chk("single_end_busy", busy4, 0);
    step();

    // Back-to-back 0 then 7 with no zero gap.
    send4(3'd0);
    send4(3'd7);
    iv4 = 1'b0;
    chk("b2b_first80", y4, 8'h80);
    for (int i = 0; i < 3; i++) step();
    chk("b2b_last80", y4, 8'h80);
    step();
    chk("b2b_end", y4, 8'h00);
    step();

    // All codes.
    for (int c = 0; c < 8; c++) begin
      send4(3'(c));
      iv4 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("all_end", y4, 8'h00);
    end

    // Reset mid-hold.
    send4(3'd6);
    iv4 = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_rdy4", rdy4, 0);
    step();
    chk("midrst_y4", y4, 8'h00);
    chk("midrst_busy4", busy4, 0);
    q4.delete();
    rst = 1'b0;
    step();
    send4(3'd1);
    iv4 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("after_rst_last", y4, 8'h02);
    step();
    chk("after_rst_end", y4, 8'h00);

    // HOLD_CYCLES=1 walk: one code per cycle.
    iv1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      c1 = 3'(c);
`ifdef DECODER_PARITY_EN
      par1 = ~(^c1);
`endif
      chk("walk_rdy1", rdy1, 1);
      q1.push_back(8'b1 << c);
      step();
    end
    iv1 = 1'b0;
    step();
    chk("walk_end_y1", y1, 8'h00);
    chk("walk_end_busy1", busy1, 0);

`ifdef DECODER_PARITY_EN
    // Good parity then bad parity.
    send4(3'd1);
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("par_good_end", y4, 8'h00);
    iv4 = 1'b1; c4 = 3'd1; par4 = 1'b1;
    chk("par_bad_rdy", rdy4, 1);
    step();
    iv4 = 1'b0;
    chk("par_err_pulse", err4, 1);
    chk("par_bad_y", y4, 8'h00);
    chk("par_bad_busy", busy4, 0);
    step();
    chk("par_err_clear", err4, 0);
`endif

    step();
    step();
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
